// File: rtl/aes_pkg.sv
// Shared AES definitions: state type, S-box RAM base addresses and the
// SubBytes engine FSM encoding.
package aes_pkg;

    typedef logic [127:0] aes_state_t;

    localparam logic [8:0] AES_SBOX_FWD_BASE = 9'h000;
    localparam logic [8:0] AES_SBOX_INV_BASE = 9'h100;
    localparam int         AES_NUM_BYTES     = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_HOLD
    } aes_sb_state_e;

    // Byte idx of a state in FIPS-197 order (byte 0 is the most significant).
    function automatic logic [7:0] aes_get_byte(aes_state_t s, logic [3:0] idx);
        logic [6:0] msb;
        msb = 7'd127 - {idx, 3'b000};
        return s[msb -: 8];
    endfunction

endpackage

// File: rtl/aes_sbox_capture.sv
// Capture side of the SubBytes engine: a READ_LATENCY-deep {valid, k} delay
// line that tracks each issued lookup pair, and the output register the
// returned S-box bytes are written into (pair k -> bytes 2k / 2k+1).
module aes_sbox_capture
    import aes_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic [2:0] issue_k,
    input  logic [7:0] sbox_douta,
    input  logic [7:0] sbox_doutb,
    output aes_state_t out_state,
    output logic       last_capture
);

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [2:0]              pipe_k [READ_LATENCY];
    logic [7:0][15:0]        out_pairs;
    logic                    emerge_valid;
    logic [2:0]              emerge_k;

    // Valid bits of the delay line; cleared by reset so in-flight reads die.
    // NOTE: sequential logic uses non-blocking (<=) so every stage samples the
    // previous value of its neighbour; blocking here would collapse the shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= issue_valid;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // Pair index travelling alongside each valid bit.
    // NOTE: payload registers are left unreset; they are only consumed when
    // the matching valid bit is set, and skipping the reset keeps them cheap.
    always_ff @(posedge clk) begin
        pipe_k[0] <= issue_k;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_k[i] <= pipe_k[i-1];
        end
    end

    assign emerge_valid = pipe_valid[READ_LATENCY-1];
    assign emerge_k     = pipe_k[READ_LATENCY-1];
    assign last_capture = emerge_valid && (emerge_k == 3'd7);

    // Write the returned byte pair into its slot; pair 0 is the top 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_pairs <= '0;
        end else if (emerge_valid) begin
            out_pairs[~emerge_k] <= {sbox_douta, sbox_doutb};
        end
    end

    assign out_state = out_pairs;

endmodule

// File: rtl/aes_sub_bytes.sv
// Iterative AES SubBytes / InvSubBytes engine driving a shared 512x8
// dual-port S-box RAM (forward table at 0x000, inverse at 0x100). Issues two
// lookups per cycle for 8 cycles, collects the bytes and holds the result
// for a valid/ready handshake.
// Build option: define AES_SUB_BYTES_INV_EN to let in_inv select the inverse
// table; without it the block is encrypt-only and in_inv is ignored.
module aes_sub_bytes
    import aes_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [8:0]   sbox_ada,
    output logic [8:0]   sbox_adb,
    output logic         sbox_cea,
    output logic         sbox_ceb,
    output logic         sbox_ocea,
    output logic         sbox_oceb,
    input  logic [7:0]   sbox_douta,
    input  logic [7:0]   sbox_doutb
);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("aes_sub_bytes: READ_LATENCY must be 1 or 2");
    end

    aes_sb_state_e state_q, state_d;
    logic [2:0]    k_q;
    aes_state_t    data_q;
    logic [8:0]    sbox_base;
    logic          accept;
    logic          last_capture;

    assign accept    = in_valid && in_ready;
    assign sbox_ocea = 1'b1;
    assign sbox_oceb = 1'b1;

`ifdef AES_SUB_BYTES_INV_EN
    logic inv_q;

    // Table select is fixed for the whole block at the input handshake.
    always_ff @(posedge clk) begin
        if (accept) begin
            inv_q <= in_inv;
        end
    end

    assign sbox_base = inv_q ? AES_SBOX_INV_BASE : AES_SBOX_FWD_BASE;
`else
    logic unused_inv;
    assign unused_inv = in_inv;
    assign sbox_base  = AES_SBOX_FWD_BASE;
`endif

    // Input state latch; only read while ISSUE is active.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q <= in_state;
        end
    end

    // FSM state register and issue counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                k_q <= 3'd0;
            end else if (state_q == ST_ISSUE) begin
                k_q <= k_q + 3'd1;
            end
        end
    end

    // Next-state, handshake and RAM port control.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sbox_ada  = '0;
        sbox_adb  = '0;
        sbox_cea  = 1'b0;
        sbox_ceb  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                sbox_cea = 1'b1;
                sbox_ceb = 1'b1;
                sbox_ada = sbox_base | {1'b0, aes_get_byte(data_q, {k_q, 1'b0})};
                sbox_adb = sbox_base | {1'b0, aes_get_byte(data_q, {k_q, 1'b1})};
                if (k_q == 3'd7) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_capture) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    aes_sbox_capture #(
        .READ_LATENCY(READ_LATENCY)
    ) u_capture (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (state_q == ST_ISSUE),
        .issue_k     (k_q),
        .sbox_douta  (sbox_douta),
        .sbox_doutb  (sbox_doutb),
        .out_state   (out_state),
        .last_capture(last_capture)
    );

endmodule

// File: tb/tb_aes_sub_bytes.sv
// Directed bench for aes_sub_bytes: one DUT at READ_LATENCY=1 on a bypass
// S-box RAM model, one at READ_LATENCY=2 on a pipelined RAM model.
module tb_aes_sub_bytes;

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [127:0] ALL_63    = {16{8'h63}};
    localparam logic [127:0] COUNT_IN  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] COUNT_OUT = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] FIPS_IN   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] DIAG_IN   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] DIAG_OUT  = 128'h638293c31bfc33f5c4eeacea4bc12816;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox_mem [512];

    // DUT at READ_LATENCY=1 (suffix _l1)
    logic         in_valid_l1 = 1'b0, in_ready_l1, in_inv_l1 = 1'b0;
    logic [127:0] in_state_l1 = '0, out_state_l1;
    logic         out_valid_l1, out_ready_l1 = 1'b0;
    logic [8:0]   ada_l1, adb_l1;
    logic         cea_l1, ceb_l1, ocea_l1, oceb_l1;
    logic [7:0]   douta_l1, doutb_l1;

    // DUT at READ_LATENCY=2 (suffix _l2)
    logic         in_valid_l2 = 1'b0, in_ready_l2, in_inv_l2 = 1'b0;
    logic [127:0] in_state_l2 = '0, out_state_l2;
    logic         out_valid_l2, out_ready_l2 = 1'b0;
    logic [8:0]   ada_l2, adb_l2;
    logic         cea_l2, ceb_l2, ocea_l2, oceb_l2;
    logic [7:0]   douta_l2, doutb_l2, pipe_a_l2, pipe_b_l2;

    int hs_l1 = 0;
    int ov_l1 = 0;

    aes_sub_bytes #(.READ_LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_l1), .in_ready(in_ready_l1), .in_state(in_state_l1), .in_inv(in_inv_l1),
        .out_valid(out_valid_l1), .out_ready(out_ready_l1), .out_state(out_state_l1),
        .sbox_ada(ada_l1), .sbox_adb(adb_l1), .sbox_cea(cea_l1), .sbox_ceb(ceb_l1),
        .sbox_ocea(ocea_l1), .sbox_oceb(oceb_l1), .sbox_douta(douta_l1), .sbox_doutb(doutb_l1)
    );

    aes_sub_bytes #(.READ_LATENCY(2)) dut_l2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_l2), .in_ready(in_ready_l2), .in_state(in_state_l2), .in_inv(in_inv_l2),
        .out_valid(out_valid_l2), .out_ready(out_ready_l2), .out_state(out_state_l2),
        .sbox_ada(ada_l2), .sbox_adb(adb_l2), .sbox_cea(cea_l2), .sbox_ceb(ceb_l2),
        .sbox_ocea(ocea_l2), .sbox_oceb(oceb_l2), .sbox_douta(douta_l2), .sbox_doutb(doutb_l2)
    );

    initial begin
        for (int i = 0; i < 256; i++) begin
            sbox_mem[i] = SBOX_FWD[i];
            sbox_mem[256 + int'(SBOX_FWD[i])] = 8'(i);
        end
    end

    // Bypass-mode RAM: data appears the cycle after the address.
    always @(posedge clk) begin
        if (reset) begin
            douta_l1 <= '0;
            doutb_l1 <= '0;
        end else begin
            if (cea_l1) douta_l1 <= sbox_mem[ada_l1];
            if (ceb_l1) doutb_l1 <= sbox_mem[adb_l1];
        end
    end

    // Pipeline-mode RAM: one extra output register stage.
    always @(posedge clk) begin
        if (reset) begin
            pipe_a_l2 <= '0; pipe_b_l2 <= '0; douta_l2 <= '0; doutb_l2 <= '0;
        end else begin
            if (cea_l2) pipe_a_l2 <= sbox_mem[ada_l2];
            if (ceb_l2) pipe_b_l2 <= sbox_mem[adb_l2];
            if (ocea_l2) douta_l2 <= pipe_a_l2;
            if (oceb_l2) doutb_l2 <= pipe_b_l2;
        end
    end

    always @(posedge clk) begin
        if (out_valid_l1 && out_ready_l1) hs_l1 <= hs_l1 + 1;
        if (out_valid_l1) ov_l1 <= ov_l1 + 1;
    end

    task automatic drive_in(input bit sel, input logic v, input logic [127:0] st, input logic inv);
        if (sel) begin in_valid_l2 = v; in_state_l2 = st; in_inv_l2 = inv; end
        else     begin in_valid_l1 = v; in_state_l1 = st; in_inv_l1 = inv; end
    endtask

    task automatic set_oready(input bit sel, input logic v);
        if (sel) out_ready_l2 = v; else out_ready_l1 = v;
    endtask

    function automatic logic iready(input bit sel);
        return sel ? in_ready_l2 : in_ready_l1;
    endfunction

    function automatic logic ovalid(input bit sel);
        return sel ? out_valid_l2 : out_valid_l1;
    endfunction

    function automatic logic [127:0] ostate(input bit sel);
        return sel ? out_state_l2 : out_state_l1;
    endfunction

    // One complete block: handshake, count cycles to out_valid, take result.
    // lat = cycles from the handshake cycle T to the first out_valid cycle.
    task automatic run_block(input bit sel, input logic [127:0] st, input logic inv,
                             output logic [127:0] res, output int lat);
        int n;
        res = '0;
        lat = -1;
        @(negedge clk);
        drive_in(sel, 1'b1, st, inv);
        n = 0;
        while (!iready(sel) && n < 40) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        drive_in(sel, 1'b0, '0, 1'b0);
        n = 1;
        while (!ovalid(sel) && n < 40) begin @(negedge clk); n++; end
        if (ovalid(sel)) begin
            lat = n;
            res = ostate(sel);
        end
        set_oready(sel, 1'b1);
        @(negedge clk);
        set_oready(sel, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (in_ready_l1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready_l1); end
        checks++; if (out_valid_l1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid_l1); end
        checks++; if (out_state_l1 !== '0) begin errors++; $display("FAIL reset_out_state got %h exp 0", out_state_l1); end
        checks++; if ({ada_l1, adb_l1} !== '0) begin errors++; $display("FAIL reset_addr got %h/%h exp 0/0", ada_l1, adb_l1); end
        checks++; if ({cea_l1, ceb_l1} !== 2'b00) begin errors++; $display("FAIL reset_ce got %b exp 00", {cea_l1, ceb_l1}); end
        checks++; if ({ocea_l1, oceb_l1} !== 2'b11) begin errors++; $display("FAIL reset_oce got %b exp 11", {ocea_l1, oceb_l1}); end
        checks++; if ({in_ready_l2, out_valid_l2} !== 2'b10) begin errors++; $display("FAIL reset_l2_hs got %b exp 10", {in_ready_l2, out_valid_l2}); end
    endtask

    task automatic test_zero;
        logic [127:0] res; int lat;
        run_block(1'b0, '0, 1'b0, res, lat);
        checks++; if (res !== ALL_63) begin errors++; $display("FAIL zero_state got %h exp %h", res, ALL_63); end
        checks++; if (lat !== 10) begin errors++; $display("FAIL zero_latency got %0d exp 10", lat); end
    endtask

    task automatic test_count;
        logic [127:0] res; int lat;
        run_block(1'b0, COUNT_IN, 1'b0, res, lat);
        checks++; if (res !== COUNT_OUT) begin errors++; $display("FAIL count_state got %h exp %h", res, COUNT_OUT); end
    endtask

    task automatic test_fips;
        logic [127:0] res; int lat;
        run_block(1'b0, FIPS_IN, 1'b0, res, lat);
        checks++; if (res !== FIPS_OUT) begin errors++; $display("FAIL fips_fwd got %h exp %h", res, FIPS_OUT); end
`ifdef AES_SUB_BYTES_INV_EN
        run_block(1'b0, FIPS_OUT, 1'b1, res, lat);
        checks++; if (res !== FIPS_IN) begin errors++; $display("FAIL fips_inv got %h exp %h", res, FIPS_IN); end
        run_block(1'b0, ALL_63, 1'b1, res, lat);
        checks++; if (res !== '0) begin errors++; $display("FAIL inv_63 got %h exp 0", res); end
`else
        run_block(1'b0, '0, 1'b1, res, lat);
        checks++; if (res !== ALL_63) begin errors++; $display("FAIL inv_ignored got %h exp %h", res, ALL_63); end
`endif
    endtask

    // Address sequence on both ports, and in_inv toggled mid-block is ignored.
    task automatic test_addresses;
        logic [8:0] exp_a, exp_b;
        int n;
        @(negedge clk);
        drive_in(1'b0, 1'b1, DIAG_IN, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive_in(1'b0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            exp_a = 9'(8'h22 * k);
            exp_b = 9'(8'h22 * k + 8'h11);
            checks++; if ({ada_l1, adb_l1} !== {exp_a, exp_b}) begin errors++; $display("FAIL addr_k%0d got %h/%h exp %h/%h", k, ada_l1, adb_l1, exp_a, exp_b); end
            checks++; if ({cea_l1, ceb_l1, in_ready_l1} !== 3'b110) begin errors++; $display("FAIL issue_ctl_k%0d got %b exp 110", k, {cea_l1, ceb_l1, in_ready_l1}); end
            @(negedge clk);
        end
        checks++; if ({cea_l1, ceb_l1, ada_l1, adb_l1} !== '0) begin errors++; $display("FAIL addr_after_issue got %b %h %h exp 0", {cea_l1, ceb_l1}, ada_l1, adb_l1); end
        n = 0;
        while (!out_valid_l1 && n < 40) begin @(negedge clk); n++; end
        checks++; if (out_state_l1 !== DIAG_OUT || !out_valid_l1) begin errors++; $display("FAIL diag_state got %h valid %b exp %h", out_state_l1, out_valid_l1, DIAG_OUT); end
        in_inv_l1 = 1'b0;
        out_ready_l1 = 1'b1;
        @(negedge clk);
        out_ready_l1 = 1'b0;
    endtask

    task automatic test_hold;
        int n, hs0;
        @(negedge clk);
        drive_in(1'b0, 1'b1, '0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive_in(1'b0, 1'b0, '0, 1'b0);
        n = 0;
        while (!out_valid_l1 && n < 40) begin @(negedge clk); n++; end
        hs0 = hs_l1;
        for (int c = 0; c < 5; c++) begin
            checks++; if ({out_valid_l1, in_ready_l1} !== 2'b10 || out_state_l1 !== ALL_63) begin
                errors++; $display("FAIL hold_c%0d got v%b r%b %h exp v1 r0 %h", c, out_valid_l1, in_ready_l1, out_state_l1, ALL_63);
            end
            @(negedge clk);
        end
        out_ready_l1 = 1'b1;
        @(negedge clk);
        out_ready_l1 = 1'b0;
        checks++; if ({out_valid_l1, in_ready_l1} !== 2'b01) begin errors++; $display("FAIL hold_release got v%b r%b exp v0 r1", out_valid_l1, in_ready_l1); end
        repeat (3) @(negedge clk);
        checks++; if (hs_l1 - hs0 !== 1) begin errors++; $display("FAIL hold_handshakes got %0d exp 1", hs_l1 - hs0); end
    endtask

    task automatic test_reset_mid;
        logic [127:0] res; int lat, ov0;
        @(negedge clk);
        drive_in(1'b0, 1'b1, COUNT_IN, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive_in(1'b0, 1'b0, '0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ov0 = ov_l1;
        checks++; if ({in_ready_l1, out_valid_l1} !== 2'b10) begin errors++; $display("FAIL midreset_release got r%b v%b exp r1 v0", in_ready_l1, out_valid_l1); end
        repeat (25) @(negedge clk);
        checks++; if (ov_l1 - ov0 !== 0) begin errors++; $display("FAIL midreset_no_valid got %0d cycles exp 0", ov_l1 - ov0); end
        checks++; if (out_state_l1 !== '0) begin errors++; $display("FAIL midreset_state got %h exp 0", out_state_l1); end
        run_block(1'b0, '0, 1'b0, res, lat);
        checks++; if (res !== ALL_63) begin errors++; $display("FAIL midreset_next got %h exp %h", res, ALL_63); end
    endtask

    task automatic test_latency2;
        logic [127:0] res; int lat;
        run_block(1'b1, COUNT_IN, 1'b0, res, lat);
        checks++; if (res !== COUNT_OUT) begin errors++; $display("FAIL l2_state got %h exp %h", res, COUNT_OUT); end
        checks++; if (lat !== 11) begin errors++; $display("FAIL l2_latency got %0d exp 11", lat); end
        run_block(1'b1, FIPS_IN, 1'b0, res, lat);
        checks++; if (res !== FIPS_OUT) begin errors++; $display("FAIL l2_back_to_back got %h exp %h", res, FIPS_OUT); end
    endtask

    initial begin
        test_reset;
        test_zero;
        test_count;
        test_fips;
        test_addresses;
        test_hold;
        test_reset_mid;
        test_latency2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
